nmi_bus_dec: RTL

//  Downstream stage of the management core: consumes the core's nmi_if master requests and

---
 rtl/nmi_dec_pkg.sv | 43 ++++
 rtl/nmi_bus_timer.sv | 42 ++++
 rtl/nmi_bus_dec.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nmi_dec_pkg.sv
// Shared types, default address map and decode helper for the nmi_if bus decoder.
package nmi_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } nmi_dec_state_e;

  localparam int NMI_DEC_MAX_SLV = 16;

  localparam logic [3:0][31:0] NMI_DEC_BASE = {32'h3000_0000, 32'h2000_0000,
                                               32'h1000_0000, 32'h0000_0000};
  localparam logic [3:0][31:0] NMI_DEC_MASK = {4{32'hF000_0000}};
  localparam logic [31:0]      NMI_DEC_ERR_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } nmi_dec_sel_t;

  // Scans downwards so the lowest-index matching region is the one left standing.
  function automatic nmi_dec_sel_t nmi_dec_sel(
    input logic [31:0]                       addr,
    input logic [NMI_DEC_MAX_SLV-1:0][31:0]  base,
    input logic [NMI_DEC_MAX_SLV-1:0][31:0]  mask,
    input int                                n_slv
  );
    nmi_dec_sel_t res;
    res.hit = 1'b0;
    res.idx = 4'd0;
    for (int i = NMI_DEC_MAX_SLV - 1; i >= 0; i--) begin
      if ((i < n_slv) && ((addr & mask[i]) == base[i])) begin
        res.hit = 1'b1;
        res.idx = 4'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nmi_bus_timer.sv
// Access watchdog for nmi_bus_dec; only built when NMI_DEC_TIMEOUT_EN is defined.
`ifdef NMI_DEC_TIMEOUT_EN
module nmi_bus_timer #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at LAST so a stuck enable cannot wrap into a false restart.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/nmi_bus_dec.sv
// Routes one nmi_if request at a time to an address-decoded slave and registers the reply.
// Optional access watchdog enabled by defining NMI_DEC_TIMEOUT_EN.
module nmi_bus_dec
  import nmi_dec_pkg::*;
#(
  parameter int                     N_SLV       = 4,
  parameter logic [N_SLV-1:0][31:0] SLV_BASE    = NMI_DEC_BASE,
  parameter logic [N_SLV-1:0][31:0] SLV_MASK    = NMI_DEC_MASK,
  parameter int                     TIMEOUT_CYC = 256,
  parameter logic [31:0]            ERR_RDATA   = NMI_DEC_ERR_RDATA
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     nmi_valid_i,
  input  logic [31:0]              nmi_addr_i,
  input  logic [31:0]              nmi_wdata_i,
  input  logic [3:0]               nmi_wstrb_i,
  output logic [31:0]              nmi_rdata_o,
  output logic                     nmi_ready_o,
  output logic [N_SLV-1:0]         slv_valid_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_wdata_o,
  output logic [3:0]               slv_wstrb_o,
  input  logic [N_SLV-1:0][31:0]   slv_rdata_i,
  input  logic [N_SLV-1:0]         slv_ready_i,
  output logic                     err_o
);

  nmi_dec_state_e state_q, state_d;
  logic [N_SLV-1:0] valid_q, valid_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             ready_q, ready_d, err_q, err_d;

  logic [NMI_DEC_MAX_SLV-1:0][31:0] base_ext_s, mask_ext_s;
  nmi_dec_sel_t     sel_s;
  logic [N_SLV-1:0] onehot_s;
  logic [31:0]      slv_rdata_mux_s;
  logic             slv_done_s;
  logic             tmr_expire_s;

  // Unused decode slots keep a zero mask but are excluded by n_slv inside the helper.
  always_comb begin
    base_ext_s = '0;
    mask_ext_s = '0;
    for (int i = 0; i < N_SLV; i++) begin
      base_ext_s[i] = SLV_BASE[i];
      mask_ext_s[i] = SLV_MASK[i];
    end
  end

  assign sel_s = nmi_dec_sel(nmi_addr_i, base_ext_s, mask_ext_s, N_SLV);

  // valid_q is non-zero only in ACC, so it doubles as the slave select.
  always_comb begin
    onehot_s        = '0;
    slv_rdata_mux_s = '0;
    for (int i = 0; i < N_SLV; i++) begin
      onehot_s[i]     = (sel_s.idx == 4'(i));
      slv_rdata_mux_s = slv_rdata_mux_s | (slv_rdata_i[i] & {32{valid_q[i]}});
    end
  end

  assign slv_done_s = |(slv_ready_i & valid_q);

`ifdef NMI_DEC_TIMEOUT_EN
  logic tmr_clr_s;
  assign tmr_clr_s = (state_q == IDLE) && nmi_valid_i && sel_s.hit;

  nmi_bus_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmr_clr_s),
    .en_i     (state_q == ACC),
    .expire_o (tmr_expire_s)
  );
`else
  assign tmr_expire_s = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (nmi_valid_i && sel_s.hit) begin
          addr_d  = nmi_addr_i;
          wdata_d = nmi_wdata_i;
          wstrb_d = nmi_wstrb_i;
          valid_d = onehot_s;
          state_d = ACC;
        end else if (nmi_valid_i) begin
          rdata_d = ERR_RDATA;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        // A slave reply in the expiry cycle still counts as a normal completion.
        if (slv_done_s) begin
          valid_d = '0;
          rdata_d = slv_rdata_mux_s;
          ready_d = 1'b1;
          state_d = RESP;
        end else if (tmr_expire_s) begin
          valid_d = '0;
          rdata_d = ERR_RDATA;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ACC;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction without a reply.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign nmi_rdata_o = rdata_q;
  assign nmi_ready_o = ready_q;
  assign slv_valid_o = valid_q;
  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;
  assign slv_wstrb_o = wstrb_q;
  assign err_o       = err_q;

endmodule
